// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: requester source encoding,
// in-flight read tags and the flush-kill helper.
package mem_arb_pkg;

  localparam int ADDR_W_DEF       = 11;
  localparam int DATA_W_DEF       = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_IF   = 2'd1,
    SRC_LD   = 2'd2,
    SRC_ST   = 2'd3
  } src_t;

  typedef struct packed {
    src_t src;
    logic kill;
  } tag_t;

  localparam tag_t TAG_EMPTY = '{src: SRC_NONE, kill: 1'b0};

  // A flush poisons fetch entries only; load/store tags pass through untouched.
  function automatic tag_t flush_kill(input tag_t t, input logic flush);
    tag_t r;
    r      = t;
    r.kill = t.kill | (flush & (t.src == SRC_IF));
    return r;
  endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// Two-stage tag pipeline for in-flight memory reads: routes mem_rvalid back to
// the issuing requester, drops flushed fetches and flags orphan responses.
module arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush_i,
  input  src_t              issue_src_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              ld_rvalid_o,
  output logic [DATA_W-1:0] ld_rdata_o,
  output logic              err_o
);

  tag_t              stage0_q, stage0_d;
  tag_t              stage1_q, stage1_d;
  tag_t              resp_tag_s;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic              err_q, err_d;
  logic              if_hit_s, ld_hit_s;

  // The stage1 entry answered this cycle is also subject to a concurrent flush.
  always_comb begin
    stage0_d   = flush_kill('{src: issue_src_i, kill: 1'b0}, flush_i);
    stage1_d   = flush_kill(stage0_q, flush_i);
    resp_tag_s = flush_kill(stage1_q, flush_i);
    if_hit_s   = mem_rvalid_i & (resp_tag_s.src == SRC_IF) & ~resp_tag_s.kill;
    ld_hit_s   = mem_rvalid_i & (resp_tag_s.src == SRC_LD);
    if_rdata_d = if_hit_s ? mem_rdata_i : if_rdata_q;
    ld_rdata_d = ld_hit_s ? mem_rdata_i : ld_rdata_q;
    err_d      = err_q | (mem_rvalid_i &
                 ((resp_tag_s.src == SRC_NONE) | (resp_tag_s.src == SRC_ST)));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stage0_q   <= TAG_EMPTY;
      stage1_q   <= TAG_EMPTY;
      if_rdata_q <= '0;
      ld_rdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      stage0_q   <= stage0_d;
      stage1_q   <= stage1_d;
      if_rdata_q <= if_rdata_d;
      ld_rdata_q <= ld_rdata_d;
      err_q      <= err_d;
    end
  end

  assign if_rvalid_o = if_hit_s;
  assign ld_rvalid_o = ld_hit_s;
  assign if_rdata_o  = if_rdata_d;
  assign ld_rdata_o  = ld_rdata_d;
  assign err_o       = err_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch, load and store: fixed priority with a
// fetch anti-starvation override, registered command issue and tagged returns.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_adrs,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              flush,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_adrs,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_adrs,
  input  logic [DATA_W-1:0] st_wdata,
  output logic              st_gnt,
  output logic              st_done,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_adrs,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              mem_r_en_q, mem_r_en_d;
  logic              mem_w_en_q, mem_w_en_d;
  logic [ADDR_W-1:0] mem_adrs_q, mem_adrs_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              force_if_s;
  src_t              issue_src_s;

  // Grant selection: store > load > fetch unless fetch has waited too long.
  always_comb begin
    force_if_s = (starve_cnt_q == CNT_MAX) & if_req & ~flush;
    st_gnt     = st_req & ~force_if_s;
    ld_gnt     = ld_req & ~st_req & ~force_if_s;
    if_gnt     = if_req & ~flush & (force_if_s | (~st_req & ~ld_req));
    if (st_gnt) begin
      issue_src_s = SRC_ST;
    end else if (ld_gnt) begin
      issue_src_s = SRC_LD;
    end else if (if_gnt) begin
      issue_src_s = SRC_IF;
    end else begin
      issue_src_s = SRC_NONE;
    end
  end

  // Starvation count and next memory command; address/data hold when idle.
  always_comb begin
    if (!if_req || if_gnt) begin
      starve_cnt_d = '0;
    end else if ((st_gnt || ld_gnt) && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
    mem_r_en_d  = ld_gnt | if_gnt;
    mem_w_en_d  = st_gnt;
    mem_wdata_d = st_gnt ? st_wdata : mem_wdata_q;
    case (issue_src_s)
      SRC_ST:  mem_adrs_d = st_adrs;
      SRC_LD:  mem_adrs_d = ld_adrs;
      SRC_IF:  mem_adrs_d = if_adrs;
      default: mem_adrs_d = mem_adrs_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_q <= '0;
      mem_r_en_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
      mem_adrs_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      mem_r_en_q   <= mem_r_en_d;
      mem_w_en_q   <= mem_w_en_d;
      mem_adrs_q   <= mem_adrs_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign mem_r_en  = mem_r_en_q;
  assign mem_w_en  = mem_w_en_q;
  assign mem_adrs  = mem_adrs_q;
  assign mem_wdata = mem_wdata_q;
  assign st_done   = mem_w_en_q;

  arb_tag_pipe #(
    .DATA_W (DATA_W)
  ) u_tag_pipe (
    .clk          (clk),
    .resetn       (resetn),
    .flush_i      (flush),
    .issue_src_i  (issue_src_s),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .if_rvalid_o  (if_rvalid),
    .if_rdata_o   (if_rdata),
    .ld_rvalid_o  (ld_rvalid),
    .ld_rdata_o   (ld_rdata),
    .err_o        (err)
  );

endmodule
